// File: rtl/seq_det_ctrl.sv
// Serial pattern detector with a loadable pattern (up to MAXLEN bits), a saturating
// match counter and a sticky threshold irq. Define SEQ_DET_CTRL_OVERLAP_EN for overlapping detection.
module seq_det_ctrl #(
    parameter int MAXLEN     = 8,
    parameter int CNTW       = 8,
    parameter int IRQ_THRESH = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cfg_load,
    input  logic            cfg_valid,
    input  logic            cfg_bit,
    input  logic            start,
    input  logic            stop,
    input  logic            in,
    input  logic            in_valid,
    output logic            out,
    output logic [CNTW-1:0] match_cnt,
    output logic            irq,
    output logic            busy,
    output logic [1:0]      state
);

    localparam int LW = $clog2(MAXLEN + 1);
    localparam logic [MAXLEN-1:0] RST_PAT = MAXLEN'(7'b1100111);
    localparam logic [LW-1:0]     RST_LEN = LW'(7);
    localparam logic [LW-1:0]     MAX_L   = LW'(MAXLEN);
    localparam logic [CNTW-1:0]   CNT_MAX = '1;
    localparam logic [CNTW-1:0]   THRESH  = CNTW'(IRQ_THRESH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CFG  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            cur_st, nxt_st;
    logic [MAXLEN-1:0] act_pat, act_pat_n, sh_pat, sh_pat_n, hist, hist_n;
    logic [LW-1:0]     act_len, act_len_n, sh_len, sh_len_n, fill, fill_n;
    logic [CNTW-1:0]   cnt, cnt_n;
    logic              irq_q, irq_n;

    logic [MAXLEN-1:0] window, mask;
    logic              fill_ok, hit;

    // Patterns are right-aligned: bit len-1 is the first expected bit, bit 0 the newest.
    always_comb begin
        window = {hist[MAXLEN-2:0], in};
        for (int i = 0; i < MAXLEN; i++) begin
            mask[i] = (i < int'(act_len));
        end
        fill_ok = ({1'b0, fill} + (LW+1)'(1)) >= {1'b0, act_len};
        hit     = (cur_st == RUN) && in_valid && fill_ok &&
                  (((window ^ act_pat) & mask) == '0);
    end

    always_comb begin
        // NOTE: every signal gets its hold value first, so no branch can leave one unassigned and infer a latch.
        nxt_st    = cur_st;
        act_pat_n = act_pat;
        act_len_n = act_len;
        sh_pat_n  = sh_pat;
        sh_len_n  = sh_len;
        hist_n    = hist;
        fill_n    = fill;
        cnt_n     = cnt;
        irq_n     = irq_q;

        unique case (cur_st)
            IDLE: begin
                if (stop) begin
                    nxt_st = IDLE;
                end else if (start) begin
                    nxt_st = RUN;
                    hist_n = '0;
                    fill_n = '0;
                    cnt_n  = '0;
                    irq_n  = 1'b0;
                end else if (cfg_load) begin
                    nxt_st   = CFG;
                    sh_pat_n = '0;
                    sh_len_n = '0;
                end
            end
            CFG: begin
                if (!cfg_load) begin
                    nxt_st = IDLE;
                    // Too-short patterns are dropped so the active pattern stays usable.
                    if (sh_len >= LW'(2)) begin
                        act_pat_n = sh_pat;
                        act_len_n = sh_len;
                    end
                end else if (cfg_valid) begin
                    sh_pat_n = {sh_pat[MAXLEN-2:0], cfg_bit};
                    sh_len_n = (sh_len == MAX_L) ? sh_len : sh_len + LW'(1);
                end
            end
            RUN: begin
                if (in_valid) begin
                    hist_n = window;
                    fill_n = (fill == MAX_L) ? fill : fill + LW'(1);
                end
                if (hit) begin
                    cnt_n = (cnt == CNT_MAX) ? cnt : cnt + CNTW'(1);
                    if (cnt_n == THRESH) begin
                        irq_n = 1'b1;
                    end
`ifdef SEQ_DET_CTRL_OVERLAP_EN
`else
                    hist_n = '0;
                    fill_n = '0;
`endif
                end
                if (stop) begin
                    nxt_st = IDLE;
                    hist_n = '0;
                    fill_n = '0;
                end else if (hit && (cnt_n == THRESH)) begin
                    nxt_st = DONE;
                end
            end
            DONE: begin
                if (stop) begin
                    nxt_st = IDLE;
                end else if (start) begin
                    nxt_st = RUN;
                    hist_n = '0;
                    fill_n = '0;
                    cnt_n  = '0;
                    irq_n  = 1'b0;
                end
            end
            default: nxt_st = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_st  <= IDLE;
            act_pat <= RST_PAT;
            act_len <= RST_LEN;
            sh_pat  <= '0;
            sh_len  <= '0;
            hist    <= '0;
            fill    <= '0;
            cnt     <= '0;
            irq_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            cur_st  <= nxt_st;
            act_pat <= act_pat_n;
            act_len <= act_len_n;
            sh_pat  <= sh_pat_n;
            sh_len  <= sh_len_n;
            hist    <= hist_n;
            fill    <= fill_n;
            cnt     <= cnt_n;
            irq_q   <= irq_n;
        end
    end

    assign out       = hit;
    assign match_cnt = cnt;
    assign irq       = irq_q;
    assign busy      = (cur_st == CFG) || (cur_st == RUN);
    assign state     = cur_st;

endmodule

// File: doc/seq_det_ctrl.md
SEQ_DET_CTRL -- requirements
Module: seq_det_ctrl

Interface
REQ-001 Parameter: MAXLEN, 8, maximum pattern length in bits (range 2..16).
REQ-002 Parameter: CNTW, 8, width of match counter.
REQ-003 Parameter: IRQ_THRESH, 3, match count that raises irq (1..2^CNTW-1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 cfg_load  input  1  level; high requests/holds configuration mode.
REQ-007 cfg_valid  input  1  qualifies cfg_bit in CFG.
REQ-008 cfg_bit  input  1  pattern bit, MSB (first-expected bit) first.
REQ-009 start  input  1  pulse; begin/restart detection.
REQ-010 stop  input  1  pulse; abort to IDLE.
REQ-011 in  input  1  serial data bit.
REQ-012 in_valid  input  1  qualifies in.
REQ-013 out  output  1  Mealy match flag, combinational from in/in_valid and current state.
REQ-014 match_cnt  output  CNTW  matches since last start, saturating.
REQ-015 irq  output  1  sticky, registered; set when match_cnt reaches IRQ_THRESH.
REQ-016 busy  output  1  high in CFG or RUN.
REQ-017 state  output  2  IDLE=0, CFG=1, RUN=2, DONE=3.

Function
REQ-018 FSM transitions: IDLE+cfg_load->CFG; IDLE+start->RUN; CFG+!cfg_load->IDLE; RUN+stop->IDLE; RUN+match making match_cnt==IRQ_THRESH->DONE; DONE+start->RUN; DONE+stop->IDLE.
REQ-019 Priority: stop over start over cfg_load in same cycle; cfg_load, cfg_valid ignored outside IDLE/CFG.
REQ-020 CFG entry clears shadow pattern and shadow length; each cfg_valid cycle shifts cfg_bit into shadow, length+1, saturating at MAXLEN (older bits discarded, last MAXLEN kept).
REQ-021 CFG exit: shadow length>=2 commits shadow to active pattern/length on the exit edge; length<2 keeps previous active pattern/length unchanged.
REQ-022 Entering RUN (from IDLE or DONE) clears bit history, fill count, match_cnt and irq in that edge.
REQ-023 RUN, in_valid=1: out=1 iff fill count>=len-1 and last len-1 history bits followed by in equal active pattern; history shifts in, fill count increments saturating at MAXLEN.
REQ-024 out=0 whenever in_valid=0 or state!=RUN; in_valid=0 cycles do not alter history.
REQ-025 match_cnt increments on each cycle out=1, saturates at 2^CNTW-1; irq sets on the edge match_cnt becomes IRQ_THRESH, holds until next RUN entry or reset.
REQ-026 stop in RUN: match_cnt and irq retain values in IDLE; history discarded.
REQ-027 Match coinciding with stop: out=1 that cycle, match counted, next state IDLE.

Reset
REQ-028 rst=0 asynchronously forces: state IDLE, active pattern 1100111 with length 7, shadow cleared, history/fill cleared, match_cnt=0, irq=0, busy=0; out=0 during reset.
REQ-029 Reset mid-CFG discards shadow; mid-RUN discards history and count; no partial commit.

Configuration
REQ-030 Macro SEQ_DET_CTRL_OVERLAP_EN defined: overlapping matches (history kept after match).
REQ-031 Macro undefined: on each match, history and fill count clear on that edge (non-overlapping detection); all else identical.

Verification
REQ-032 Reset, start, in stream 0011001110011101100111 (one bit/cycle), OVERLAP_EN defined -> out pulses at bits 9,14,22; match_cnt=3; irq=1 after bit 22; state=DONE.
REQ-033 Same stream, OVERLAP_EN undefined -> out at bits 9,22 only; match_cnt=2; irq=0; state=RUN.
REQ-034 cfg_load with cfg_bits 1,0,1 then release; start; stream 10101 -> out at bits 3 and 5 (overlap build); match_cnt=2.
REQ-035 cfg_load with single cfg_bit then release -> active pattern remains 1100111; bits 3-9 of REQ-032 stream still match at bit 9.
REQ-036 start and stop asserted together in IDLE -> stays IDLE; rst=0 mid-RUN after 2 matches -> match_cnt=0, irq=0, state=IDLE immediately (no clock).
REQ-037 in_valid low for 3 cycles between pattern bits 4 and 5 -> match still detected at final valid bit.
